// File: rtl/fmdll_lock_ctrl_pkg.sv
// Shared types and default dimensions for the FMDLL frequency-lock controller.
package fmdll_lock_ctrl_pkg;

  localparam int CODE_W_DEF   = 8;
  localparam int CNT_W_DEF    = 12;
  localparam int WIN_DEF      = 256;
  localparam int SETTLE_DEF   = 16;
  localparam int LOCK_CNT_DEF = 4;
  localparam int TOL_DEF      = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SAR   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SAR   = ST_SAR,
    TRACK = ST_TRACK
  } lock_state_e;

  typedef enum logic [1:0] {
    M_OFF,
    M_SETTLE,
    M_WIN
  } meas_phase_e;

endpackage

// File: rtl/fmdll_lock_ctrl_if.sv
// Control/status bundle between the lock controller and its environment.
interface fmdll_lock_ctrl_if #(
  parameter int CODE_W = 8,
  parameter int CNT_W  = 12
);
  logic              en;
  logic              n_tgl;
  logic [CNT_W-1:0]  exp_cnt;
  logic [CODE_W-1:0] dco_code;
  logic              locked;
  logic [1:0]        state;
  logic              meas_valid;
  logic [CNT_W-1:0]  meas_cnt;

  modport master (
    output en, n_tgl, exp_cnt,
    input  dco_code, locked, state, meas_valid, meas_cnt
  );

  modport slave (
    input  en, n_tgl, exp_cnt,
    output dco_code, locked, state, meas_valid, meas_cnt
  );
endinterface

// File: rtl/fmdll_lock_ctrl_win_meas.sv
// Window measurement: synchronises n_tgl, waits SETTLE cycles, then counts
// toggle events over WIN cycles and reports the total one cycle later.
module fmdll_lock_ctrl_win_meas
  import fmdll_lock_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WIN    = WIN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk_ext,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             n_tgl_i,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] meas_cnt_o
);

  localparam int TW = $clog2((WIN > SETTLE) ? WIN : SETTLE);
  localparam logic [TW-1:0]    WIN_LAST    = TW'(WIN - 1);
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [2:0]       sync_q;
  logic             ev;
  meas_phase_e      phase_q, phase_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] ev_q, ev_d, ev_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  // Two flops resynchronise n_tgl; the third holds the previous level for edge detection.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], n_tgl_i};
    end
  end

  assign ev     = sync_q[1] ^ sync_q[2];
  assign ev_inc = (ev && (ev_q != CNT_MAX)) ? ev_q + 1'b1 : ev_q;

  always_comb begin
    phase_d = phase_q;
    tmr_d   = tmr_q;
    ev_d    = ev_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (abort_i) begin
      phase_d = M_OFF;
      tmr_d   = '0;
      ev_d    = '0;
      cnt_d   = '0;
    end else if (start_i) begin
      phase_d = M_SETTLE;
      tmr_d   = '0;
      ev_d    = '0;
    end else begin
      case (phase_q)
        M_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            phase_d = M_WIN;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        M_WIN: begin
          ev_d = ev_inc;
          if (tmr_q == WIN_LAST) begin
            phase_d = M_OFF;
            tmr_d   = '0;
            valid_d = 1'b1;
            cnt_d   = ev_inc;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= M_OFF;
      tmr_q   <= '0;
      ev_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tmr_q   <= tmr_d;
      ev_q    <= ev_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign meas_valid_o = valid_q;
  assign meas_cnt_o   = cnt_q;

endmodule

// File: rtl/fmdll_lock_ctrl.sv
// FMDLL frequency-lock controller: binary SAR search of the DCO code, then
// +/-1 tracking with a lock flag after consecutive in-tolerance windows.
module fmdll_lock_ctrl
  import fmdll_lock_ctrl_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WIN      = WIN_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int TOL      = TOL_DEF
) (
  input  logic             clk_ext,
  input  logic             rst_n,
  fmdll_lock_ctrl_if.slave bus
);

  localparam int BIT_W = $clog2(CODE_W);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0]   CODE_RST = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0]   CODE_MAX = '1;
  localparam logic [BIT_W-1:0]    BIT_TOP  = BIT_W'(CODE_W - 1);
  localparam logic [RUN_W-1:0]    RUN_MAX  = RUN_W'(LOCK_CNT);
  localparam logic signed [CNT_W:0] TOL_S  = (CNT_W+1)'(TOL);

  lock_state_e         state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic                locked_q, locked_d;
  logic                start_q, start_d;
  logic                meas_valid;
  logic [CNT_W-1:0]    meas_cnt;
  logic signed [CNT_W:0] err;

  fmdll_lock_ctrl_win_meas #(
    .CNT_W  (CNT_W),
    .WIN    (WIN),
    .SETTLE (SETTLE)
  ) u_win_meas (
    .clk_ext      (clk_ext),
    .rst_n        (rst_n),
    .start_i      (start_q),
    .abort_i      (!bus.en),
    .n_tgl_i      (bus.n_tgl),
    .meas_valid_o (meas_valid),
    .meas_cnt_o   (meas_cnt)
  );

  assign err = $signed({1'b0, meas_cnt}) - $signed({1'b0, bus.exp_cnt});

  // Decisions happen only on the meas_valid cycle; start_q then reopens settle+window.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    bit_d    = bit_q;
    run_d    = run_q;
    locked_d = locked_q;
    start_d  = 1'b0;
    if (!bus.en) begin
      state_d  = IDLE;
      code_d   = CODE_RST;
      bit_d    = BIT_TOP;
      run_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SAR;
          code_d   = CODE_RST;
          bit_d    = BIT_TOP;
          run_d    = '0;
          locked_d = 1'b0;
          start_d  = 1'b1;
        end
        SAR: begin
          if (meas_valid) begin
            start_d = 1'b1;
            if (meas_cnt > bus.exp_cnt) begin
              code_d[bit_q] = 1'b0;
            end
            if (bit_q == '0) begin
              state_d = TRACK;
            end else begin
              code_d[bit_q - 1'b1] = 1'b1;
              bit_d                = bit_q - 1'b1;
            end
          end
        end
        TRACK: begin
          if (meas_valid) begin
            start_d = 1'b1;
            if (err < -TOL_S) begin
              if (code_q != CODE_MAX) code_d = code_q + 1'b1;
              run_d    = '0;
              locked_d = 1'b0;
            end else if (err > TOL_S) begin
              if (code_q != '0) code_d = code_q - 1'b1;
              run_d    = '0;
              locked_d = 1'b0;
            end else begin
              if (run_q != RUN_MAX) run_d = run_q + 1'b1;
              locked_d = (run_d == RUN_MAX);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= CODE_RST;
      bit_q    <= BIT_TOP;
      run_q    <= '0;
      locked_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      bit_q    <= bit_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      start_q  <= start_d;
    end
  end

  assign bus.dco_code   = code_q;
  assign bus.locked     = locked_q;
  assign bus.state      = state_q;
  assign bus.meas_valid = meas_valid;
  assign bus.meas_cnt   = meas_cnt;

endmodule
